// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the two requester handshakes (instruction fetch and load/store),
//   the external SRAM port and the stall request that mem_arbiter serves.
//
//   Requester side : inst_req/inst_addr -> inst_ack/inst_rdata
//                    data_req/data_we/data_sel/data_addr/data_wdata
//                                        -> data_ack/data_rdata
//   SRAM side      : sram_ce/sram_we/sram_sel/sram_addr/sram_wdata
//                                        <- sram_rdata
//   Control        : stallreq to the pipeline controller
//
//   Modports:
//     slave  - the arbiter (accepts requests, drives the SRAM port)
//     master - the environment (requesters, SRAM model, controller)
interface mem_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic              inst_req;
    logic [31:0]       inst_addr;
    logic              inst_ack;
    logic [31:0]       inst_rdata;

    logic              data_req;
    logic              data_we;
    logic [3:0]        data_sel;
    logic [31:0]       data_addr;
    logic [31:0]       data_wdata;
    logic              data_ack;
    logic [31:0]       data_rdata;

    logic              sram_ce;
    logic              sram_we;
    logic [3:0]        sram_sel;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    logic              stallreq;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_we, data_sel, data_addr, data_wdata,
        input  sram_rdata,
        output inst_ack, inst_rdata,
        output data_ack, data_rdata,
        output sram_ce, sram_we, sram_sel, sram_addr, sram_wdata,
        output stallreq
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_we, data_sel, data_addr, data_wdata,
        output sram_rdata,
        input  inst_ack, inst_rdata,
        input  data_ack, data_rdata,
        input  sram_ce, sram_we, sram_sel, sram_addr, sram_wdata,
        input  stallreq
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one external SRAM port between the instruction-fetch requester
//   and the load/store requester. One access is in flight at a time: the
//   granted request is driven onto the SRAM for WAIT_CYCLES cycles, read
//   data is captured at the end of the last access cycle, and a one-cycle
//   ack follows. Simultaneous requests alternate between the two sides.
//
//   Parameters:
//     ADDR_W      - SRAM word-address width (sram_addr = addr[ADDR_W+1:2]),
//                   at most 29
//     WAIT_CYCLES - SRAM access cycles per transaction, 1..15
//
//   Ports:
//     clk - clock, all state updates on the rising edge
//     rst - synchronous active-high reset
//     bus - mem_arbiter_if.slave: requester handshakes, SRAM port, stallreq
module mem_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic       GRANT_INST = 1'b0;
    localparam logic       GRANT_DATA = 1'b1;
    localparam logic [3:0] CNT_INIT   = 4'(WAIT_CYCLES - 1);

    state_t            state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        cnt_q,        cnt_d;
    logic              sram_ce_q,    sram_ce_d;
    logic              sram_we_q,    sram_we_d;
    logic [3:0]        sram_sel_q,   sram_sel_d;
    logic [ADDR_W-1:0] sram_addr_q,  sram_addr_d;
    logic [31:0]       sram_wdata_q, sram_wdata_d;
    logic              inst_ack_q,   inst_ack_d;
    logic              data_ack_q,   data_ack_d;
    logic [31:0]       inst_rdata_q, inst_rdata_d;
    logic [31:0]       data_rdata_q, data_rdata_d;
    logic              pick_data;

    // Byte-offset bits and address bits above the SRAM range are not used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.inst_addr[31:ADDR_W+2], bus.inst_addr[1:0],
                                bus.data_addr[31:ADDR_W+2], bus.data_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        sram_ce_d    = sram_ce_q;
        sram_we_d    = sram_we_q;
        sram_sel_d   = sram_sel_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        // Acks are pulses: they only survive the cycle they are set for.
        inst_ack_d   = 1'b0;
        data_ack_d   = 1'b0;
        pick_data    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.inst_req || bus.data_req) begin
                    // On a tie the side that was not served last time wins.
                    pick_data = bus.data_req &&
                                (!bus.inst_req || last_grant_q == GRANT_INST);
                    sram_ce_d = 1'b1;
                    if (pick_data) begin
                        sram_we_d    = bus.data_we;
                        sram_sel_d   = bus.data_sel;
                        sram_addr_d  = bus.data_addr[ADDR_W+1:2];
                        sram_wdata_d = bus.data_wdata;
                    end else begin
                        sram_we_d    = 1'b0;
                        sram_sel_d   = 4'b1111;
                        sram_addr_d  = bus.inst_addr[ADDR_W+1:2];
                        sram_wdata_d = '0;
                    end
                    cnt_d        = CNT_INIT;
                    last_grant_d = pick_data ? GRANT_DATA : GRANT_INST;
                    state_d      = ACCESS;
                end
            end

            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // last_grant_q still names the side being served here.
                    if (!sram_we_q) begin
                        if (last_grant_q == GRANT_DATA) begin
                            data_rdata_d = bus.sram_rdata;
                        end else begin
                            inst_rdata_d = bus.sram_rdata;
                        end
                    end
                    if (last_grant_q == GRANT_DATA) begin
                        data_ack_d = 1'b1;
                    end else begin
                        inst_ack_d = 1'b1;
                    end
                    sram_ce_d    = 1'b0;
                    sram_we_d    = 1'b0;
                    sram_sel_d   = '0;
                    sram_addr_d  = '0;
                    sram_wdata_d = '0;
                    state_d      = DONE;
                end
            end

            // The ack is visible in this cycle; the requester drops or renews
            // its request before the next arbitration in IDLE.
            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_INST;
            cnt_q        <= '0;
            sram_ce_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_sel_q   <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            sram_ce_q    <= sram_ce_d;
            sram_we_q    <= sram_we_d;
            sram_sel_q   <= sram_sel_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            inst_ack_q   <= inst_ack_d;
            data_ack_q   <= data_ack_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign bus.sram_ce    = sram_ce_q;
    assign bus.sram_we    = sram_we_q;
    assign bus.sram_sel   = sram_sel_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;
    assign bus.inst_ack   = inst_ack_q;
    assign bus.data_ack   = data_ack_q;
    assign bus.inst_rdata = inst_rdata_q;
    assign bus.data_rdata = data_rdata_q;

    // A requester stalls the pipeline until its ack cycle.
    assign bus.stallreq = !rst && ((bus.inst_req && !inst_ack_q) ||
                                   (bus.data_req && !data_ack_q));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Index 0: arbiter with WAIT_CYCLES=1, index 1: WAIT_CYCLES=3.
    logic        rst_s  [2];
    logic        ireq   [2];
    logic [31:0] iaddr  [2];
    logic        dreq   [2];
    logic        dwe    [2];
    logic [3:0]  dsel   [2];
    logic [31:0] daddr  [2];
    logic [31:0] dwdata [2];
    logic [31:0] noise  [2];
    logic [31:0] srd    [2];

    logic        o_iack   [2];
    logic        o_dack   [2];
    logic [31:0] o_irdata [2];
    logic [31:0] o_drdata [2];
    logic        o_ce     [2];
    logic        o_we     [2];
    logic [3:0]  o_sel    [2];
    logic [19:0] o_addr   [2];
    logic [31:0] o_wdata  [2];
    logic        o_stall  [2];

    // SRAM contents seen by the arbiters.
    function automatic logic [31:0] rd_word(input logic [19:0] a);
        case (a)
            20'h00004: return 32'h2401_0005;
            20'h00080: return 32'h1111_2222;
            default:   return {12'hC0D, a};
        endcase
    endfunction

    function automatic int wc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mem_arbiter_if #(.ADDR_W(20)) bus ();

        mem_arbiter #(.ADDR_W(20), .WAIT_CYCLES(k == 0 ? 1 : 3)) u_dut (
            .clk (clk),
            .rst (rst_s[k]),
            .bus (bus.slave)
        );

        assign bus.inst_req   = ireq[k];
        assign bus.inst_addr  = iaddr[k];
        assign bus.data_req   = dreq[k];
        assign bus.data_we    = dwe[k];
        assign bus.data_sel   = dsel[k];
        assign bus.data_addr  = daddr[k];
        assign bus.data_wdata = dwdata[k];
        assign srd[k]         = rd_word(bus.sram_addr) ^ noise[k];
        assign bus.sram_rdata = srd[k];

        assign o_iack[k]   = bus.inst_ack;
        assign o_dack[k]   = bus.data_ack;
        assign o_irdata[k] = bus.inst_rdata;
        assign o_drdata[k] = bus.data_rdata;
        assign o_ce[k]     = bus.sram_ce;
        assign o_we[k]     = bus.sram_we;
        assign o_sel[k]    = bus.sram_sel;
        assign o_addr[k]   = bus.sram_addr;
        assign o_wdata[k]  = bus.sram_wdata;
        assign o_stall[k]  = bus.stallreq;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-timeline model: a grant decided in cycle g drives the
    // SRAM in cycles g+1..g+W, samples read data at the end of g+W, acks
    // in g+W+1, and the arbiter is free to decide again in g+W+2.
    // ------------------------------------------------------------------
    int          cyc       [2] = '{0, 0};
    int          gcyc      [2] = '{0, 0};
    bit          busy      [2] = '{0, 0};
    bit          gdata     [2] = '{0, 0};
    bit          last_data [2] = '{0, 0};
    bit          armed     [2] = '{0, 0};
    logic [31:0] s_addr    [2];
    logic        s_we      [2];
    logic [3:0]  s_sel     [2];
    logic [31:0] s_wdata   [2];
    logic [31:0] m_irdata  [2];
    logic [31:0] m_drdata  [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_s[k]) begin
                busy[k]      <= 1'b0;
                last_data[k] <= 1'b0;
                m_irdata[k]  <= '0;
                m_drdata[k]  <= '0;
                armed[k]     <= 1'b1;
            end else if (busy[k]) begin
                if (cyc[k] - gcyc[k] == wc(k) && !s_we[k]) begin
                    if (gdata[k]) m_drdata[k] <= srd[k];
                    else          m_irdata[k] <= srd[k];
                end
                if (cyc[k] - gcyc[k] == wc(k) + 1) busy[k] <= 1'b0;
            end else if (ireq[k] || dreq[k]) begin
                gdata[k]     <= dreq[k] && (!ireq[k] || !last_data[k]);
                last_data[k] <= dreq[k] && (!ireq[k] || !last_data[k]);
                gcyc[k]      <= cyc[k];
                busy[k]      <= 1'b1;
                if (dreq[k] && (!ireq[k] || !last_data[k])) begin
                    s_addr[k]  <= daddr[k];
                    s_we[k]    <= dwe[k];
                    s_sel[k]   <= dsel[k];
                    s_wdata[k] <= dwdata[k];
                end else begin
                    s_addr[k]  <= iaddr[k];
                    s_we[k]    <= 1'b0;
                    s_sel[k]   <= 4'b1111;
                    s_wdata[k] <= '0;
                end
            end
            cyc[k] <= cyc[k] + 1;
        end
    end

    function automatic bit m_act(input int k);
        return busy[k] && (cyc[k] - gcyc[k] >= 1) && (cyc[k] - gcyc[k] <= wc(k));
    endfunction

    function automatic bit m_ack(input int k);
        return busy[k] && (cyc[k] - gcyc[k] == wc(k) + 1);
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (armed[k]) begin
                chk($sformatf("dut%0d sram_ce", k), 32'(o_ce[k]), 32'(m_act(k)));
                chk($sformatf("dut%0d sram_we", k), 32'(o_we[k]), 32'(m_act(k) && s_we[k]));
                chk($sformatf("dut%0d sram_sel", k), 32'(o_sel[k]), m_act(k) ? 32'(s_sel[k]) : 32'h0);
                chk($sformatf("dut%0d sram_addr", k), 32'(o_addr[k]), m_act(k) ? 32'(s_addr[k][21:2]) : 32'h0);
                chk($sformatf("dut%0d sram_wdata", k), o_wdata[k], m_act(k) ? s_wdata[k] : 32'h0);
                chk($sformatf("dut%0d inst_ack", k), 32'(o_iack[k]), 32'(m_ack(k) && !gdata[k]));
                chk($sformatf("dut%0d data_ack", k), 32'(o_dack[k]), 32'(m_ack(k) && gdata[k]));
                chk($sformatf("dut%0d inst_rdata", k), o_irdata[k], m_irdata[k]);
                chk($sformatf("dut%0d data_rdata", k), o_drdata[k], m_drdata[k]);
                chk($sformatf("dut%0d stallreq", k), 32'(o_stall[k]),
                    rst_s[k] ? 32'h0 :
                    32'((ireq[k] && !(m_ack(k) && !gdata[k])) || (dreq[k] && !(m_ack(k) && gdata[k]))));
            end
        end
    end

    // Advance to just after the next rising edge / to the sampling point.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_s[k] = 1'b1;  ireq[k] = 1'b0;  iaddr[k] = '0;
            dreq[k]  = 1'b0;  dwe[k]  = 1'b0;  dsel[k]  = '0;
            daddr[k] = '0;    dwdata[k] = '0;  noise[k] = '0;
        end
        nxt();
        nxt();
        smp();
        chk("reset ce", 32'(o_ce[0]), 32'h0);
        chk("reset addr", 32'(o_addr[1]), 32'h0);
        chk("reset iack", 32'(o_iack[0]), 32'h0);
        chk("reset stall", 32'(o_stall[0]), 32'h0);

        // Single fetch on the W=1 arbiter.
        nxt();
        rst_s[0] = 1'b0;  rst_s[1] = 1'b0;
        ireq[0] = 1'b1;   iaddr[0] = 32'h0000_0010;
        smp();
        chk("fetch c0 stall", 32'(o_stall[0]), 32'h1);
        nxt(); smp();
        chk("fetch c1 addr", 32'(o_addr[0]), 32'h4);
        chk("fetch c1 ce", 32'(o_ce[0]), 32'h1);
        chk("fetch c1 we", 32'(o_we[0]), 32'h0);
        chk("fetch c1 stall", 32'(o_stall[0]), 32'h1);
        nxt(); smp();
        chk("fetch c2 ack", 32'(o_iack[0]), 32'h1);
        chk("fetch c2 rdata", o_irdata[0], 32'h2401_0005);
        chk("fetch c2 stall", 32'(o_stall[0]), 32'h0);

        // Load then store on the W=1 arbiter.
        nxt();
        ireq[0] = 1'b0;
        dreq[0] = 1'b1; dwe[0] = 1'b0; dsel[0] = 4'hF; daddr[0] = 32'h0000_0200;
        nxt(); nxt(); smp();
        chk("load ack", 32'(o_dack[0]), 32'h1);
        chk("load rdata", o_drdata[0], 32'h1111_2222);
        nxt();
        dwe[0] = 1'b1; dsel[0] = 4'b0011; daddr[0] = 32'h0000_0100; dwdata[0] = 32'hDEAD_BEEF;
        nxt(); smp();
        chk("store we", 32'(o_we[0]), 32'h1);
        chk("store sel", 32'(o_sel[0]), 32'h3);
        chk("store addr", 32'(o_addr[0]), 32'h40);
        chk("store wdata", o_wdata[0], 32'hDEAD_BEEF);
        nxt(); smp();
        chk("store ack", 32'(o_dack[0]), 32'h1);
        chk("store keeps rdata", o_drdata[0], 32'h1111_2222);
        nxt();
        dreq[0] = 1'b0; dwe[0] = 1'b0;
        smp();
        chk("store ack single", 32'(o_dack[0]), 32'h0);

        // Tie right after reset: DATA first, then alternation.
        rst_s[0] = 1'b1;
        nxt();
        rst_s[0] = 1'b0;
        ireq[0] = 1'b1; iaddr[0] = 32'h0000_0040;
        dreq[0] = 1'b1; dsel[0] = 4'hF; daddr[0] = 32'h0000_0300;
        nxt(); smp();
        chk("tie1 addr", 32'(o_addr[0]), 32'hC0);
        nxt(); smp();
        chk("tie1 dack", 32'(o_dack[0]), 32'h1);
        chk("tie1 iack", 32'(o_iack[0]), 32'h0);
        chk("tie1 stall", 32'(o_stall[0]), 32'h1);
        nxt();
        daddr[0] = 32'h0000_0200;
        nxt(); smp();
        chk("tie2 addr", 32'(o_addr[0]), 32'h10);
        nxt(); smp();
        chk("tie2 iack", 32'(o_iack[0]), 32'h1);
        chk("tie2 rdata", o_irdata[0], 32'hC0D0_0010);
        nxt();
        ireq[0] = 1'b0;
        nxt(); smp();
        chk("tie3 addr", 32'(o_addr[0]), 32'h80);
        nxt(); smp();
        chk("tie3 dack", 32'(o_dack[0]), 32'h1);
        chk("tie3 rdata", o_drdata[0], 32'h1111_2222);
        nxt();
        dreq[0] = 1'b0;

        // W=3 load, with a fetch arriving during the data access.
        dreq[1] = 1'b1; dwe[1] = 1'b0; dsel[1] = 4'hF; daddr[1] = 32'h0000_0200;
        nxt();
        noise[1] = 32'hFFFF_0000;
        smp();
        chk("w3 c1 ce", 32'(o_ce[1]), 32'h1);
        chk("w3 c1 addr", 32'(o_addr[1]), 32'h80);
        nxt();
        ireq[1] = 1'b1; iaddr[1] = 32'h0000_0010;
        smp();
        chk("w3 c2 ce", 32'(o_ce[1]), 32'h1);
        nxt();
        noise[1] = 32'h0;
        smp();
        chk("w3 c3 addr", 32'(o_addr[1]), 32'h80);
        chk("w3 c3 stall", 32'(o_stall[1]), 32'h1);
        nxt();
        noise[1] = 32'h0000_FFFF;
        smp();
        chk("w3 c4 dack", 32'(o_dack[1]), 32'h1);
        chk("w3 c4 rdata", o_drdata[1], 32'h1111_2222);
        chk("w3 c4 stall", 32'(o_stall[1]), 32'h1);
        nxt();
        dreq[1] = 1'b0; noise[1] = 32'h0;
        smp();
        chk("w3 c5 stall", 32'(o_stall[1]), 32'h1);
        chk("w3 c5 ce", 32'(o_ce[1]), 32'h0);
        nxt(); smp();
        chk("w3 c6 addr", 32'(o_addr[1]), 32'h4);
        nxt(); nxt(); nxt(); smp();
        chk("w3 c9 iack", 32'(o_iack[1]), 32'h1);
        chk("w3 c9 rdata", o_irdata[1], 32'h2401_0005);
        chk("w3 c9 stall", 32'(o_stall[1]), 32'h0);

        // Reset during a W=3 load access, request held across it.
        nxt();
        ireq[1] = 1'b0;
        dreq[1] = 1'b1; daddr[1] = 32'h0000_0200;
        nxt();
        nxt();
        rst_s[1] = 1'b1;
        smp();
        chk("rst c2 stall", 32'(o_stall[1]), 32'h0);
        nxt();
        rst_s[1] = 1'b0;
        smp();
        chk("rst c3 ce", 32'(o_ce[1]), 32'h0);
        chk("rst c3 addr", 32'(o_addr[1]), 32'h0);
        chk("rst c3 dack", 32'(o_dack[1]), 32'h0);
        chk("rst c3 rdata", o_drdata[1], 32'h0);
        nxt(); smp();
        chk("rst c4 ce", 32'(o_ce[1]), 32'h1);
        nxt(); nxt(); nxt(); smp();
        chk("rst c7 dack", 32'(o_dack[1]), 32'h1);
        chk("rst c7 rdata", o_drdata[1], 32'h1111_2222);
        nxt();
        dreq[1] = 1'b0;
        nxt(); nxt(); smp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter that shares a single external SRAM port between the instruction-fetch requester (pc_reg/if_id side) and the load/store requester (mem stage). It grants one access at a time, drives the SRAM for a programmable number of wait cycles and returns read data with a one-cycle acknowledge. It raises a stall request to ctrl while any requester is waiting, alongside the existing stallreq_from_id and stallreq_from_mem requests.

## Interface
- ADDR_W, 20, SRAM word-address width.
- WAIT_CYCLES, 1, SRAM access cycles per transaction; legal range 1..15.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  instruction fetch request; held until inst_ack.
- inst_addr  in  32  byte address of the fetch; bits [1:0] ignored.
- inst_ack  out  1  one-cycle pulse when the fetch has completed.
- inst_rdata  out  32  fetched word; valid from the inst_ack cycle until the next inst completion.
- data_req  in  1  load/store request; held until data_ack.
- data_we  in  1  1 = store, 0 = load.
- data_sel  in  4  byte enables, active-high.
- data_addr  in  32  byte address; bits [1:0] ignored.
- data_wdata  in  32  store data.
- data_ack  out  1  one-cycle completion pulse.
- data_rdata  out  32  load result; updated on loads only.
- sram_ce  out  1  SRAM chip enable, active-high.
- sram_we  out  1  SRAM write enable, active-high.
- sram_sel  out  4  SRAM byte enables.
- sram_addr  out  ADDR_W  word address, taken from req_addr[ADDR_W+1:2].
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data.
- stallreq  out  1  pipeline stall request to ctrl.

## Operation
- FSM states: IDLE, ACCESS, DONE. A grant register last_grant records INST or DATA.
- **IDLE**
  - No request: stay in IDLE with all sram_* outputs at 0.
  - One request: grant it.
  - Both requesting: grant the requester opposite to last_grant.
  - On a grant: register sram_ce=1, addr, sel, wdata and we from the granted requester. A fetch drives sel=4'b1111 and we=0. Load cnt=WAIT_CYCLES-1, update last_grant, go to ACCESS.
- **ACCESS**
  - Hold all sram_* outputs stable.
  - cnt≠0: decrement cnt.
  - cnt==0: on a read, capture sram_rdata into the granted requester's rdata register. Set the granted requester's ack, clear all sram_* outputs to 0, go to DONE.
- **DONE**
  - The ack is high for exactly this cycle. Go to IDLE.
  - No arbitration happens in DONE. The requester drops or renews its request after seeing ack, so a stale request is never served twice.
- stallreq = (inst_req & ~inst_ack) | (data_req & ~data_ack). It is combinational and forced to 0 while rst=1.
- Requesters must keep req and their address/data fields stable from assertion through ack. Changes before ack are undefined.

## Timing
- Reset values, applied on the first rising edge with rst=1:
  - state=IDLE, last_grant=INST (so the first tie goes to DATA).
  - sram_ce, sram_we, sram_sel, sram_addr, sram_wdata all 0.
  - inst_ack, data_ack = 0; inst_rdata, data_rdata = 0.
- Latency, with the request seen in IDLE at cycle 0:
  - SRAM is driven during cycles 1..WAIT_CYCLES.
  - sram_rdata is sampled at the end of cycle WAIT_CYCLES.
  - ack is high in cycle WAIT_CYCLES+1.
  - The earliest next grant is decided in cycle WAIT_CYCLES+2.
  - Throughput is one access per WAIT_CYCLES+2 cycles.
- A request that arrives while the FSM is in ACCESS or DONE waits, with stallreq=1, until the next IDLE.
- rst asserted mid-ACCESS or in DONE: the next edge returns every output to its reset value, the transaction is abandoned and no ack is issued.
- WAIT_CYCLES=1 gives cnt=0 on entry. ACCESS then lasts one cycle, for a total latency of 3 cycles.

## Test plan
- Reset, then a single fetch with inst_addr=0x0000_0010, WAIT_CYCLES=1 and sram_rdata=0x2401_0005 -> sram_addr=0x4 with ce=1 and we=0 in cycle 1; inst_ack=1 with inst_rdata=0x2401_0005 in cycle 2; stallreq=1 in cycles 0-1 and 0 in cycle 2.
- Store with data_addr=0x0000_0100, sel=4'b0011, wdata=0xDEAD_BEEF -> sram_we=1, sram_sel=4'b0011, sram_addr=0x40, sram_wdata=0xDEAD_BEEF; data_ack pulses once; data_rdata keeps its prior value.
- Both requests asserted first after reset -> DATA is granted first and INST is granted at the next IDLE. A repeated tie then grants INST first (alternation).
- WAIT_CYCLES=3 with a load -> sram outputs stable for 3 cycles, data_ack in cycle 4, sram_rdata latched from the end of cycle 3.
- rst pulsed during ACCESS of a load -> next edge: all sram_* = 0, no data_ack, state IDLE. With the request still held after rst drops, the access restarts normally.
- Fetch request arriving during a data ACCESS -> stallreq stays 1 and the fetch is granted in the IDLE cycle after the data DONE.
